// File: rtl/board_pkg.sv
// Shared types and colour constants for the Battleship board renderer.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } fsm_t;

    // RGB565 palette
    localparam logic [15:0] WATER  = 16'h001F;
    localparam logic [15:0] GRID_C = 16'h4208;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] GRAY   = 16'h8410;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLACK  = 16'h0000;

    typedef struct packed {
        logic [1:0]  board;
        logic [3:0]  row;
        logic [3:0]  col;
        cell_state_t state;
    } wr_entry_t;

endpackage

// File: rtl/wq_fifo.sv
// Small synchronous FIFO for queued cell writes; flush empties it in one cycle.
module wq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/board_renderer.sv
// Pixel generator for NUM_BOARDS Battleship grids with cursor; cell writes are
// queued and committed only during vertical blanking so frames never tear.
module board_renderer
    import board_pkg::*;
#(
    parameter int NUM_BOARDS  = 2,
    parameter int GRID        = 10,
    parameter int CELL_LOG2   = 5,
    parameter int BOARD_X0    = 16,
    parameter int BOARD_PITCH = 320,
    parameter int BOARD_Y     = 80,
    parameter int V_ACTIVE    = 480,
    parameter int WQ_DEPTH    = 4
) (
    input  logic       vga_clk,
    input  logic       rst_n,
    input  logic [9:0] next_x,
    input  logic [9:0] next_y,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_board,
    input  logic [3:0] wr_row,
    input  logic [3:0] wr_col,
    input  logic [1:0] wr_state,
    input  logic       clr_req,
    input  logic       cur_en,
    input  logic [1:0] cur_board,
    input  logic [3:0] cur_row,
    input  logic [3:0] cur_col,
    output logic [7:0] r_in,
    output logic [7:0] g_in,
    output logic [7:0] b_in,
    output logic       busy
);
    localparam int CELL    = 1 << CELL_LOG2;
    localparam int BOARD_W = GRID * CELL;
    localparam int NCELLS  = NUM_BOARDS * GRID * GRID;
    localparam int IDX_W   = $clog2(NCELLS);
    localparam int MISS_LO = CELL/4 + CELL/8;
    localparam int MISS_HI = CELL - MISS_LO;

    fsm_t             state_q, state_d;
    logic [1:0]       cells [NCELLS];
    logic [IDX_W-1:0] sweep_q;
    logic             clear_pending;
    logic             blank, sweep_last;
    logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic             clear_en, commit_en, commit_ok;
    logic [IDX_W-1:0] commit_idx;
    wr_entry_t        wr_entry, head;

    assign blank = (next_y >= 10'(V_ACTIVE));

    // Write handshake: an entry transfers on any clock where wr_valid && wr_ready;
    // wr_ready depends only on registered state, never on wr_valid.
    assign wr_ready  = !fifo_full && !clear_pending && (state_q != CLEAR);
    assign busy      = clear_pending || (state_q == CLEAR) || !fifo_empty;
    assign fifo_push = wr_valid && wr_ready;
    assign wr_entry  = '{board: wr_board, row: wr_row, col: wr_col, state: cell_state_t'(wr_state)};

    wq_fifo #(.DEPTH(WQ_DEPTH), .WIDTH($bits(wr_entry_t))) u_wq (
        .clk   (vga_clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign sweep_last = (sweep_q == IDX_W'(NCELLS - 1));
    assign commit_ok  = (int'(head.board) < NUM_BOARDS) && (int'(head.row) < GRID)
                        && (int'(head.col) < GRID);
    assign commit_idx = IDX_W'((int'(head.board) * GRID + int'(head.row)) * GRID + int'(head.col));

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        clear_en   = 1'b0;
        commit_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (blank && clear_pending)    state_d = CLEAR;
                else if (blank && !fifo_empty) state_d = DRAIN;
            end
            CLEAR: begin
                if (!blank) begin
                    state_d = IDLE;
                end else begin
                    clear_en = 1'b1;
                    if (sweep_last) begin
                        fifo_flush = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (!blank || fifo_empty) begin
                    state_d = IDLE;
                end else begin
                    fifo_pop  = 1'b1;
                    commit_en = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sweep index is held across active video so an interrupted clear resumes.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCELLS; i++) cells[i] <= EMPTY;
            sweep_q       <= '0;
            clear_pending <= 1'b0;
        end else begin
            if (clear_en) begin
                cells[sweep_q] <= EMPTY;
                sweep_q        <= sweep_last ? '0 : sweep_q + 1'b1;
            end
            if (commit_en && commit_ok) cells[commit_idx] <= head.state;
            if (clear_en && sweep_last) clear_pending <= 1'b0;
            else if (clr_req)           clear_pending <= 1'b1;
        end
    end

    logic [10:0]          dx, dy;
    logic                 in_b, cur_hit, cur_edge;
    logic [1:0]           pboard;
    logic [3:0]           prow, pcol;
    logic [CELL_LOG2-1:0] lx, ly;
    logic [IDX_W-1:0]     pix_idx;
    int                   diag_a, diag_b;
    logic [15:0]          colour;

    always_comb begin
        dy     = {1'b0, next_y} - 11'(BOARD_Y);
        dx     = '0;
        in_b   = 1'b0;
        pboard = '0;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (({1'b0, next_x} - 11'(BOARD_X0 + b * BOARD_PITCH)) < 11'(BOARD_W)) begin
                in_b   = 1'b1;
                pboard = 2'(b);
                dx     = {1'b0, next_x} - 11'(BOARD_X0 + b * BOARD_PITCH);
            end
        end
        in_b     = in_b && (dy < 11'(BOARD_W));
        lx       = dx[CELL_LOG2-1:0];
        ly       = dy[CELL_LOG2-1:0];
        pcol     = 4'(dx >> CELL_LOG2);
        prow     = 4'(dy >> CELL_LOG2);
        pix_idx  = in_b ? IDX_W'((int'(pboard) * GRID + int'(prow)) * GRID + int'(pcol)) : '0;
        cur_hit  = cur_en && (cur_board == pboard) && (cur_row == prow) && (cur_col == pcol);
        cur_edge = (lx == CELL_LOG2'(1)) || (lx == CELL_LOG2'(CELL - 1))
                   || (ly == CELL_LOG2'(1)) || (ly == CELL_LOG2'(CELL - 1));
        diag_a   = int'(lx) - int'(ly);
        diag_b   = int'(lx) + int'(ly) - (CELL - 1);
        colour   = BLACK;
        if (in_b) begin
            if (cur_hit && cur_edge) begin
                colour = YELLOW;
            end else if (lx == '0 || ly == '0) begin
                colour = GRID_C;
            end else begin
                case (cell_state_t'(cells[pix_idx]))
                    HIT:  colour = ((diag_a >= -1 && diag_a <= 1) || (diag_b >= -1 && diag_b <= 1))
                                   ? RED : WATER;
                    MISS: colour = (lx >= CELL_LOG2'(MISS_LO) && lx < CELL_LOG2'(MISS_HI)
                                    && ly >= CELL_LOG2'(MISS_LO) && ly < CELL_LOG2'(MISS_HI))
                                   ? WHITE : WATER;
                    SHIP:    colour = GRAY;
                    default: colour = WATER;
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in <= '0;
            g_in <= '0;
            b_in <= '0;
        end else begin
            r_in <= {colour[15:11], 3'b000};
            g_in <= {colour[10:5], 2'b00};
            b_in <= {colour[4:0], 3'b000};
        end
    end

endmodule
